bcd_to_bin_convert: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any digit >= 8).
- Inverse of the existing binary-to-BCD path. Turns multi-digit decimal values (score/time digits, user-entered thresholds) back into binary for compare and arithmetic logic.
- Same start/ready handshake style as the binary-to-BCD converter, so the two chain back-to-back.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/bcd_to_bin_convert.sv | 112 +++++++++++
 tb/tb_bcd_to_bin_convert.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding and
// the digit constants used by the reverse double-dabble adjust step.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADJ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DIGIT_W       = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int ADJ_THRESH    = 8;
  localparam int ADJ_CONST     = 3;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational adjust for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  // A digit of 8+ after a right shift only happens when a 1 fell in from the
  // digit above; that bit is worth 5 here, not 8.
  assign d_o = (d_i >= DIGIT_W'(ADJ_THRESH)) ? d_i - DIGIT_W'(ADJ_CONST) : d_i;

endmodule

// File: rtl/bcd_to_bin_convert.sv
// Sequential BCD-to-binary converter (reverse double-dabble, start/ready handshake).
// Optional load-time digit validation enabled by defining BCD_VALID_CHECK_EN.
module bcd_to_bin_convert
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]      bin_d_out,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic                invalid_q, invalid_d;
  logic [BCD_W-1:0]    adjBcd;
  logic                anyInvalid;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (work_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .d_o (adjBcd[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_VALID_CHECK_EN
  always_comb begin
    anyInvalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_d_in[i*DIGIT_W +: DIGIT_W])) anyInvalid = 1'b1;
    end
  end
`else
  assign anyInvalid = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    err_d     = err_q;
    invalid_d = invalid_q;
    rdy_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          work_d    = {bcd_d_in, {BIN_W{1'b0}}};
          cnt_d     = '0;
          invalid_d = anyInvalid;
          state_d   = anyInvalid ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d  = work_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(BIN_W - 1)) ? DONE : ADJ;
      end
      ADJ: begin
        work_d  = {adjBcd, work_q[BIN_W-1:0]};
        state_d = SHIFT;
      end
      DONE: begin
        bin_d   = work_q[BIN_W-1:0];
        err_d   = invalid_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      invalid_q <= invalid_d;
    end
  end

  assign bin_d_out = bin_q;
  assign rdy       = rdy_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_to_bin_convert.sv
// Self-checking bench for bcd_to_bin_convert: directed corner cases plus
// random decimal values checked against an arithmetic digit-sum model.
module tb_bcd_to_bin_convert;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 2 * BIN_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [15:0]       bcd_d_in = '0;
  logic [BIN_W-1:0]  bin_d_out;
  logic              rdy;
  logic              busy;
  logic              err;

  int vectorCount = 0;
  int missCount   = 0;

  bcd_to_bin_convert #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: decimal weight of each nibble, truncated to the output width.
  function automatic int modelBin(input logic [15:0] bcd);
    int acc = 0;
    int weight = 1;
    for (int i = 0; i < DIGITS; i++) begin
      acc += int'(bcd[i*4 +: 4]) * weight;
      weight *= 10;
    end
    return acc % (1 << BIN_W);
  endfunction

  function automatic logic [15:0] toBcd(input int value);
    logic [15:0] r = '0;
    int v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Waits for rdy, returning edges elapsed since the accepting edge and
  // whether busy stayed high until the completion cycle.
  task automatic waitRdy(output int lat, output logic busyOk);
    lat = 0;
    busyOk = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!rdy && !busy) busyOk = 1'b0;
    end while (!rdy && lat < 200);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] bcd,
                               input int expBin, input logic expErr, input int expLat);
    int lat;
    logic busyOk;
    @(negedge clk);
    en = 1'b1;
    bcd_d_in = bcd;
    @(posedge clk); #1;
    en = 1'b0;
    checkOutput({tag, "_busyRise"}, 32'(busy), 32'd1);
    waitRdy(lat, busyOk);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_bin"}, 32'(bin_d_out), 32'(expBin));
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    checkOutput({tag, "_busyFall"}, 32'(busy), 32'd0);
    checkOutput({tag, "_busyHeld"}, 32'(busyOk), 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_rdyPulse"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic busyOk;
    logic [15:0] r;

    #2 reset = 1'b1;
    #1;
    checkOutput("reset_bin", 32'(bin_d_out), 32'd0);
    checkOutput("reset_rdy", 32'(rdy), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus("zero", 16'h0000, 0, 1'b0, LAT);
    applyStimulus("max", 16'h9999, 9999, 1'b0, LAT);
    applyStimulus("loop1234", 16'h1234, 1234, 1'b0, LAT);
`ifdef BCD_VALID_CHECK_EN
    applyStimulus("invalid", 16'h12A4, 0, 1'b1, 1);
`else
    applyStimulus("invalid", 16'h12A4, modelBin(16'h12A4), 1'b0, LAT);
`endif

    for (int i = 0; i < 30; i++) begin
      r = toBcd(int'($urandom_range(0, 9999)));
      applyStimulus("random", r, modelBin(r), 1'b0, LAT);
    end
    for (int v = 0; v < 4096; v += 511) begin
      applyStimulus("sweep", toBcd(v), v, 1'b0, LAT);
    end

    // Second request while busy must be dropped.
    @(negedge clk);
    en = 1'b1;
    bcd_d_in = 16'h0042;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    bcd_d_in = 16'h0777;
    @(negedge clk);
    en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (rdy) begin
        pulses++;
        checkOutput("busyDrop_bin", 32'(bin_d_out), 32'd42);
      end
    end
    checkOutput("busyDrop_pulses", 32'(pulses), 32'd1);

    // en held high: next request accepted in the rdy cycle.
    @(negedge clk);
    en = 1'b1;
    bcd_d_in = 16'h0321;
    @(posedge clk); #1;
    bcd_d_in = 16'h0654;
    waitRdy(lat, busyOk);
    checkOutput("b2b_lat1", 32'(lat), 32'(LAT));
    checkOutput("b2b_bin1", 32'(bin_d_out), 32'd321);
    @(posedge clk); #1;
    en = 1'b0;
    checkOutput("b2b_busy2", 32'(busy), 32'd1);
    waitRdy(lat, busyOk);
    checkOutput("b2b_lat2", 32'(lat), 32'(LAT));
    checkOutput("b2b_bin2", 32'(bin_d_out), 32'd654);
    checkOutput("b2b_busyHeld", 32'(busyOk), 32'd1);

    // Reset mid-conversion clears outputs at once and suppresses rdy.
    @(negedge clk);
    en = 1'b1;
    bcd_d_in = 16'h0500;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset_rdy", 32'(rdy), 32'd0);
    checkOutput("midReset_busy", 32'(busy), 32'd0);
    checkOutput("midReset_err", 32'(err), 32'd0);
    checkOutput("midReset_bin", 32'(bin_d_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rdy) pulses++;
    end
    checkOutput("midReset_noRdy", 32'(pulses), 32'd0);
    applyStimulus("afterReset", 16'h0500, 500, 1'b0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
